// File: rtl/audio_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : audio_filter_ctrl
// Desc    : Time-shares one moving-average filter between L/R codec channels.
//           Optional macro AUDIO_FILTER_CTRL_BYPASS_EN adds a per-frame bypass.
// Rev     : 1.0  initial release
// ============================================================================
module audio_filter_ctrl #(
    parameter int W        = 24,
    parameter int FILT_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             read_ready,
    output logic             read,
    input  logic [W-1:0]     readdata_left,
    input  logic [W-1:0]     readdata_right,
`ifdef AUDIO_FILTER_CTRL_BYPASS_EN
    input  logic             bypass,
`endif
    input  logic             write_ready,
    output logic             write,
    output logic [W-1:0]     writedata_left,
    output logic [W-1:0]     writedata_right,
    output logic             filt_en,
    output logic             filt_ch,
    output logic [W-1:0]     filt_din,
    input  logic [W-1:0]     filt_dout,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [3:0] LAT_CNT = 4'(FILT_LAT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FEED_L = 3'd1,
        WAIT_L = 3'd2,
        FEED_R = 3'd3,
        WAIT_R = 3'd4,
        WRITE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [W-1:0]     left_q, left_d;
    logic [W-1:0]     right_q, right_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic             filt_en_q, filt_en_d;
    logic             filt_ch_q, filt_ch_d;
    logic [W-1:0]     filt_din_q, filt_din_d;
    logic [W-1:0]     wdl_q, wdl_d;
    logic [W-1:0]     wdr_q, wdr_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             cap_l_q, cap_l_d;
    logic             cap_r_q, cap_r_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            filt_en_q   <= 1'b0;
            filt_ch_q   <= 1'b0;
            filt_din_q  <= '0;
            wdl_q       <= '0;
            wdr_q       <= '0;
            frame_cnt_q <= '0;
            cap_l_q     <= 1'b0;
            cap_r_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            right_q     <= right_d;
            read_q      <= read_d;
            write_q     <= write_d;
            filt_en_q   <= filt_en_d;
            filt_ch_q   <= filt_ch_d;
            filt_din_q  <= filt_din_d;
            wdl_q       <= wdl_d;
            wdr_q       <= wdr_d;
            frame_cnt_q <= frame_cnt_d;
            cap_l_q     <= cap_l_d;
            cap_r_q     <= cap_r_d;
        end
    end

    // Strobes are registered, so the filter sees filt_en one cycle after the
    // FEED state; the result is therefore sampled the cycle after WAIT ends.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        right_d     = right_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        filt_en_d   = 1'b0;
        filt_ch_d   = filt_ch_q;
        filt_din_d  = filt_din_q;
        wdl_d       = cap_l_q ? filt_dout : wdl_q;
        wdr_d       = cap_r_q ? filt_dout : wdr_q;
        frame_cnt_d = frame_cnt_q;
        cap_l_d     = 1'b0;
        cap_r_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_ready) begin
                    read_d  = 1'b1;
                    left_d  = readdata_left;
                    right_d = readdata_right;
                    state_d = FEED_L;
`ifdef AUDIO_FILTER_CTRL_BYPASS_EN
                    if (bypass) begin
                        wdl_d   = readdata_left;
                        wdr_d   = readdata_right;
                        state_d = WRITE;
                    end
`endif
                end
            end
            FEED_L: begin
                filt_en_d  = 1'b1;
                filt_ch_d  = 1'b0;
                filt_din_d = left_q;
                cnt_d      = LAT_CNT;
                state_d    = WAIT_L;
            end
            WAIT_L: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    cap_l_d = 1'b1;
                    state_d = FEED_R;
                end
            end
            FEED_R: begin
                filt_en_d  = 1'b1;
                filt_ch_d  = 1'b1;
                filt_din_d = right_q;
                cnt_d      = LAT_CNT;
                state_d    = WAIT_R;
            end
            WAIT_R: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    cap_r_d = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (write_ready) begin
                    write_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign read            = read_q;
    assign write           = write_q;
    assign writedata_left  = wdl_q;
    assign writedata_right = wdr_q;
    assign filt_en         = filt_en_q;
    assign filt_ch         = filt_ch_q;
    assign filt_din        = filt_din_q;
    assign busy            = (state_q != IDLE);
    assign frame_cnt       = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_audio_filter_ctrl
// Desc    : Directed bench for audio_filter_ctrl (LAT=1 and LAT=3/CNT_W=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_audio_filter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: default parameters
    logic        read_ready = 1'b0, write_ready = 1'b1;
    logic [23:0] rd_l = '0, rd_r = '0;
    logic        read, write, filt_en, filt_ch, busy;
    logic [23:0] wdl, wdr, filt_din;
    logic [23:0] filt_dout = '0;
    logic [15:0] frame_cnt;
`ifdef AUDIO_FILTER_CTRL_BYPASS_EN
    logic        byp = 1'b0;
`endif

    // Instance 2: FILT_LAT=3, CNT_W=4
    logic        rr2 = 1'b0, wr2 = 1'b1;
    logic [23:0] l2 = '0, r2 = '0;
    logic        read2, write2, filt_en2, filt_ch2, busy2;
    logic [23:0] wdl2, wdr2, filt_din2;
    logic [23:0] s0 = '0, s1 = '0, s2 = '0;
    logic [3:0]  frame_cnt2;

    audio_filter_ctrl dut (
        .clock(clk), .reset(rst_n),
        .read_ready(read_ready), .read(read),
        .readdata_left(rd_l), .readdata_right(rd_r),
`ifdef AUDIO_FILTER_CTRL_BYPASS_EN
        .bypass(byp),
`endif
        .write_ready(write_ready), .write(write),
        .writedata_left(wdl), .writedata_right(wdr),
        .filt_en(filt_en), .filt_ch(filt_ch), .filt_din(filt_din),
        .filt_dout(filt_dout), .busy(busy), .frame_cnt(frame_cnt)
    );

    audio_filter_ctrl #(.W(24), .FILT_LAT(3), .CNT_W(4)) dut2 (
        .clock(clk), .reset(rst_n),
        .read_ready(rr2), .read(read2),
        .readdata_left(l2), .readdata_right(r2),
`ifdef AUDIO_FILTER_CTRL_BYPASS_EN
        .bypass(1'b0),
`endif
        .write_ready(wr2), .write(write2),
        .writedata_left(wdl2), .writedata_right(wdr2),
        .filt_en(filt_en2), .filt_ch(filt_ch2), .filt_din(filt_din2),
        .filt_dout(s2), .busy(busy2), .frame_cnt(frame_cnt2)
    );

    // Filter models: result = 2*din, latency 1 and 3 cycles respectively
    always_ff @(posedge clk) begin
        if (filt_en) filt_dout <= filt_din << 1;
        if (filt_en2) s0 <= filt_din2 << 1;
        s1 <= s0;
        s2 <= s1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_read1();
        int t = 0;
        @(negedge clk);
        while (!read && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("read_ack", 32'(read), 32'd1);
    endtask

    task automatic run_frame(input logic [23:0] l, input logic [23:0] r,
                             input logic [23:0] el, input logic [23:0] er,
                             input logic [15:0] ecnt);
        rd_l = l;
        rd_r = r;
        read_ready = 1'b1;
        wait_read1();
        read_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("filt_en", 32'(filt_en), 32'(c == 1 || c == 3));
            if (c == 1 || c == 3) begin
                chk("filt_ch", 32'(filt_ch), 32'(c == 3));
                chk("filt_din", 32'(filt_din), 32'((c == 1) ? l : r));
            end
            chk("read_quiet", 32'(read), 32'd0);
            chk("write_time", 32'(write), 32'(c == 5));
        end
        chk("wd_left", 32'(wdl), 32'(el));
        chk("wd_right", 32'(wdr), 32'(er));
        chk("frame_cnt", 32'(frame_cnt), 32'(ecnt));
    endtask

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] el;
        logic [23:0] er;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'h000100, 24'h000200, 24'h000200, 24'h000400};
        vecs[1] = '{24'h7FFFFF, 24'h800000, 24'hFFFFFE, 24'h000000};
        vecs[2] = '{24'hABCDEF, 24'h000001, 24'h579BDE, 24'h000002};
        vecs[3] = '{24'h123456, 24'hFFFFFF, 24'h2468AC, 24'hFFFFFE};

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            read_ready  = 1'($urandom);
            write_ready = 1'($urandom);
            rd_l        = 24'($urandom);
            rd_r        = 24'($urandom);
        end
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_filt_en", 32'(filt_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wdl", 32'(wdl), 32'd0);
        chk("rst_wdr", 32'(wdr), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        read_ready  = 1'b0;
        write_ready = 1'b1;
        rst_n       = 1'b1;
        @(negedge clk);

        // Table-driven frames, no backpressure
        for (int v = 0; v < 4; v++)
            run_frame(vecs[v].l, vecs[v].r, vecs[v].el, vecs[v].er, 16'(v + 1));

        // Backpressure: 10 refused cycles in WRITE, read_ready held high
        write_ready = 1'b0;
        rd_l = 24'h000010;
        rd_r = 24'h000020;
        read_ready = 1'b1;
        wait_read1();
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk("bp_read", 32'(read), 32'd0);
            if (c >= 5) begin
                chk("bp_write", 32'(write), 32'd0);
                chk("bp_wdl", 32'(wdl), 32'h000020);
                chk("bp_wdr", 32'(wdr), 32'h000040);
                chk("bp_busy", 32'(busy), 32'd1);
            end
        end
        write_ready = 1'b1;
        @(negedge clk);
        chk("bp_write_go", 32'(write), 32'd1);
        chk("bp_frame_cnt", 32'(frame_cnt), 32'd5);
        chk("bp_read_hold", 32'(read), 32'd0);
        @(negedge clk);
        chk("bp_next_read", 32'(read), 32'd1);
        read_ready = 1'b0;
        begin
            int t = 0;
            @(negedge clk);
            while (!write && t < 30) begin
                @(negedge clk);
                t++;
            end
        end
        chk("bp2_write", 32'(write), 32'd1);
        chk("bp2_frame_cnt", 32'(frame_cnt), 32'd6);

        // Reset asserted during WAIT_R
        @(negedge clk);
        rd_l = 24'h000001;
        rd_r = 24'h000003;
        read_ready = 1'b1;
        wait_read1();
        read_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_filt_en_r", 32'(filt_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_read", 32'(read), 32'd0);
        chk("mid_write", 32'(write), 32'd0);
        chk("mid_filt_en", 32'(filt_en), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_wdl", 32'(wdl), 32'd0);
        chk("mid_wdr", 32'(wdr), 32'd0);
        chk("mid_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(24'h000005, 24'h000006, 24'h00000A, 24'h00000C, 16'd1);

`ifdef AUDIO_FILTER_CTRL_BYPASS_EN
        // Bypass frame: straight to WRITE, filter untouched
        byp  = 1'b1;
        rd_l = 24'h123456;
        rd_r = 24'h654321;
        read_ready = 1'b1;
        wait_read1();
        read_ready = 1'b0;
        chk("byp_filt_en0", 32'(filt_en), 32'd0);
        @(negedge clk);
        chk("byp_write", 32'(write), 32'd1);
        chk("byp_wdl", 32'(wdl), 32'h123456);
        chk("byp_wdr", 32'(wdr), 32'h654321);
        chk("byp_filt_en1", 32'(filt_en), 32'd0);
        chk("byp_frame_cnt", 32'(frame_cnt), 32'd2);
        @(negedge clk);
        chk("byp_filt_en2", 32'(filt_en), 32'd0);
        byp = 1'b0;
`endif

        // FILT_LAT=3, CNT_W=4: 16 back-to-back frames, wrap and latency
        l2  = 24'h000100;
        r2  = 24'h000300;
        rr2 = 1'b1;
        for (int f = 0; f < 16; f++) begin
            logic [23:0] el;
            logic [23:0] er;
            int t;
            int lat;
            t = 0;
            @(negedge clk);
            while (!read2 && t < 30) begin
                @(negedge clk);
                t++;
            end
            chk("w_read", 32'(read2), 32'd1);
            el = l2 << 1;
            er = r2 << 1;
            l2 = l2 + 24'h000111;
            r2 = r2 + 24'h000222;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!write2 && lat < 30);
            chk("w_latency", 32'(lat), 32'd9);
            chk("w_wdl", 32'(wdl2), 32'(el));
            chk("w_wdr", 32'(wdr2), 32'(er));
            chk("w_frame_cnt", 32'(frame_cnt2), 32'((f + 1) % 16));
        end
        rr2 = 1'b0;
        chk("w_wrap_zero", 32'(frame_cnt2), 32'd0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_filter_ctrl.md
Name: audio_filter_ctrl

Overview:
- Sequences one shared moving-average filter engine between the left and right audio channels.
- Sits between the codec read/write handshake and the filter datapath.
- Reads one stereo frame, then feeds the filter left then right with one-cycle enable strobes. Captures each result after a fixed latency and writes the filtered frame back to the codec.
- The filter holds per-channel state banks selected by filt_ch; only this block advances them.

Parameters:
- W, 24, sample width in bits.
- FILT_LAT, 1, cycles from a filt_en cycle until filt_dout is valid. Legal range is 1..15.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- read_ready  in  1  codec has a frame; readdata is held valid while high.
- read  out  1  one-cycle read acknowledge.
- readdata_left  in  W  left input sample.
- readdata_right  in  W  right input sample.
- write_ready  in  1  codec can accept a frame.
- write  out  1  one-cycle write strobe.
- writedata_left  out  W  filtered left sample.
- writedata_right  out  W  filtered right sample.
- filt_en  out  1  filter advances state this cycle.
- filt_ch  out  1  filter channel bank: 0 = left, 1 = right.
- filt_din  out  W  sample presented to the filter.
- filt_dout  in  W  filter result.
- busy  out  1  high whenever state is not IDLE.
- frame_cnt  out  CNT_W  completed frames; wraps.

Behaviour:
- Reset (reset low, asynchronous):
  - state goes to IDLE.
  - All outputs and internal registers clear to 0.
  - Any in-flight frame is discarded; no partial write ever occurs.
- States: IDLE, FEED_L, WAIT_L, FEED_R, WAIT_R, WRITE.
- All outputs are registered or decoded from state; there is no combinational path from input to output.
- IDLE:
  - If read_ready=1: read=1 for this cycle only, capture both readdata ports into internal regs, go to FEED_L.
  - Otherwise read=0, stay.
- FEED_L:
  - filt_en=1, filt_ch=0, filt_din=left reg, for exactly one cycle.
  - Load wait counter with FILT_LAT; go to WAIT_L.
- WAIT_L:
  - filt_en=0; counter decrements each cycle.
  - On the cycle the counter reaches 1, capture filt_dout into writedata_left and go to FEED_R.
  - WAIT_L lasts exactly FILT_LAT cycles.
- FEED_R / WAIT_R: identical to FEED_L / WAIT_L with filt_ch=1 and the right sample; the result is captured into writedata_right.
- WRITE:
  - writedata holds stable.
  - If write_ready=1: write=1 for one cycle, frame_cnt += 1 (modulo 2^CNT_W), go to IDLE.
  - Otherwise write=0; stay indefinitely (backpressure).
- filt_ch holds its last value when filt_en=0; filt_din holds its value outside FEED states.
- Timing:
  - Read at cycle 0 gives the earliest write at cycle 2*FILT_LAT+3 (cycle 5 for FILT_LAT=1).
  - Minimum frame period is 2*FILT_LAT+4 cycles.
- read_ready high while busy is ignored; read stays 0. The codec keeps holding the frame until the next IDLE.
- write_ready high outside WRITE is ignored.
- Exactly two filt_en pulses per frame, ordered left then right.
- Never a filt_en pulse without a subsequent write attempt, except when aborted by reset.
- Arithmetic: no arithmetic on samples (pass-through of W bits). frame_cnt wraps from all-ones to 0 silently.

Optional Feature:
- Macro: AUDIO_FILTER_CTRL_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit), sampled in IDLE on the read cycle.
  - If bypass=1, the FSM goes IDLE to WRITE directly, with writedata = captured readdata.
  - filt_en stays 0 for that frame, so filter state is untouched. frame_cnt still increments on write.
- When undefined: no bypass port; every frame is filtered.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles with random inputs -> read, write, filt_en, busy, writedata_left, writedata_right and frame_cnt are all 0.
- Single frame, FILT_LAT=1, filter model dout=2*din registered:
  - Stimulus: read_ready=1, L=0x000100, R=0x000200, write_ready=1.
  - Required: read at cycle 0; filt_en at cycles 1 (ch0, din 0x000100) and 3 (ch1, din 0x000200); write at cycle 5 with 0x000200/0x000400; frame_cnt=1.
- Backpressure: write_ready=0 for 10 cycles in WRITE -> write=0, writedata stable, read stays 0 despite read_ready=1. Write pulses on the first cycle write_ready=1; the next read follows one cycle later.
- Reset mid-frame: pull reset low during WAIT_R -> outputs 0 in that cycle with no clock edge needed. After release, the next frame completes normally and frame_cnt=1.
- Wrap and latency: CNT_W=4, FILT_LAT=3, 16 back-to-back frames -> frame_cnt returns to 0. Each write occurs exactly 9 cycles after its read.
- With AUDIO_FILTER_CTRL_BYPASS_EN, bypass=1, L=0x123456 -> no filt_en; write at cycle 1 with writedata_left=0x123456.
